// File: rtl/half_adder_unit.sv
// -----------------------------------------------------------------------------
// half_adder_unit
//
// Purpose:
//   Registered, lane-parallel half adder with a valid/ready handshake on both
//   sides. Each of the WIDTH lanes computes sum = a ^ b and carry = a & b
//   independently (no carry ripple between lanes). The result is held in a
//   one-entry output register that can be drained and refilled in the same
//   cycle, so it sustains one result per clock while downstream is ready.
//
// Optional feature (macro HALF_ADDER_UNIT_STATS_EN):
//   Adds saturating transaction / carry statistics counters plus a
//   synchronous clear input. Without the macro those ports and counters do
//   not exist and the core behaviour is unchanged.
//
// Parameters:
//   WIDTH  number of independent half-adder lanes (>= 1)
//   CNT_W  statistics counter width (only meaningful with the stats feature)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   in_valid     in   a/b carry a valid operand pair this cycle
//   in_ready     out  operands can be accepted this cycle (combinational)
//   a, b         in   [WIDTH] operands, one bit per lane
//   out_valid    out  sum/carry/carry_any hold a valid result
//   out_ready    in   downstream takes the result this cycle
//   sum          out  [WIDTH] registered a ^ b of the accepted operands
//   carry        out  [WIDTH] registered a & b of the accepted operands
//   carry_any    out  registered OR-reduction of carry
//   stats_clear  in   (stats only) zero both counters
//   txn_count    out  [CNT_W] (stats only) saturating count of accepts
//   carry_count  out  [CNT_W] (stats only) saturating count of accepts that
//                     produced at least one carry
// -----------------------------------------------------------------------------
module half_adder_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any
`ifdef HALF_ADDER_UNIT_STATS_EN
  ,
  input  logic             stats_clear,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] carry_count
`endif
);

  // Illegal parameter values show up as these named (empty) scopes in the
  // elaborated hierarchy; legal configurations never create them.
  if (WIDTH < 1) begin : g_invalid_width
  end
  if (CNT_W < 1) begin : g_invalid_cnt_w
  end

  // Output register state.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic [WIDTH-1:0] carry_q,     carry_d;
  logic             carry_any_q, carry_any_d;

  // Handshake qualifiers and the raw per-lane arithmetic.
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_carry;
  logic             lane_carry_any;

  // The slot can take a new operand pair when it is empty or when the held
  // result leaves this same cycle; this is what gives bubble-free streaming.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // Per-lane half add. Lanes are independent, so this is plain bitwise logic.
  assign lane_sum       = a ^ b;
  assign lane_carry     = a & b;
  assign lane_carry_any = |lane_carry;

  // Next state of the output slot. An accept always wins: if the old result
  // is draining at the same time, the new one simply replaces it and
  // out_valid stays high. A drain without an accept only clears out_valid;
  // the data registers keep their stale contents to save enable logic.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_any_d = carry_any_q;
    if (accept) begin
      out_valid_d = 1'b1;
      sum_d       = lane_sum;
      carry_d     = lane_carry;
      carry_any_d = lane_carry_any;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot registers; reset clears the data too so a freshly reset
  // block presents all-zero outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      carry_any_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_any_q <= carry_any_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign carry_any = carry_any_q;

`ifdef HALF_ADDER_UNIT_STATS_EN
  logic [CNT_W-1:0] txn_count_q,   txn_count_d;
  logic [CNT_W-1:0] carry_count_q, carry_count_d;

  // Statistics counters. A clear takes precedence over a coincident accept,
  // and both counters stick at all-ones instead of wrapping so a long run
  // never reads back as a small number.
  always_comb begin
    txn_count_d   = txn_count_q;
    carry_count_d = carry_count_q;
    if (stats_clear) begin
      txn_count_d   = '0;
      carry_count_d = '0;
    end else if (accept) begin
      if (txn_count_q != '1) begin
        txn_count_d = txn_count_q + CNT_W'(1);
      end
      if (lane_carry_any && (carry_count_q != '1)) begin
        carry_count_d = carry_count_q + CNT_W'(1);
      end
    end
  end

  // Counter registers, cleared by reset like the rest of the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count_q   <= '0;
      carry_count_q <= '0;
    end else begin
      txn_count_q   <= txn_count_d;
      carry_count_q <= carry_count_d;
    end
  end

  assign txn_count   = txn_count_q;
  assign carry_count = carry_count_q;
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_half_adder_unit
//
// Drives half_adder_unit (WIDTH=8, CNT_W=4) through directed and randomized
// steps and compares every cycle against a behavioural model that keeps the
// held result as a simple record and computes it with plain XOR/AND/OR.
// The 1-bit truth table is exercised on lane 0 with the other lanes at zero.
// Stats checks are compiled in when HALF_ADDER_UNIT_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_half_adder_unit;

  localparam int W      = 8;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         carry_any;
  logic         stats_clear;
`ifdef HALF_ADDER_UNIT_STATS_EN
  logic [CW-1:0] txn_count;
  logic [CW-1:0] carry_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: the result currently held downstream-visible.
  bit           m_init  = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_known = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic [W-1:0] m_carry = '0;
  logic         m_any   = 1'b0;
  int           m_txn   = 0;
  int           m_cc    = 0;

  always #5 clk = ~clk;

  half_adder_unit #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .carry      (carry),
    .carry_any  (carry_any)
`ifdef HALF_ADDER_UNIT_STATS_EN
    ,
    .stats_clear(stats_clear),
    .txn_count  (txn_count),
    .carry_count(carry_count)
`endif
  );

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Compare all registered outputs with the model; data is only meaningful
  // while a result is held (or right after reset, when it must be zero).
  task automatic checkOutput();
    checkEq("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_known) begin
      checkEq("sum", {24'b0, sum}, {24'b0, m_sum});
      checkEq("carry", {24'b0, carry}, {24'b0, m_carry});
      checkEq("carry_any", {31'b0, carry_any}, {31'b0, m_any});
    end
`ifdef HALF_ADDER_UNIT_STATS_EN
    checkEq("txn_count", {28'b0, txn_count}, m_txn);
    checkEq("carry_count", {28'b0, carry_count}, m_cc);
`endif
  endtask

  // Apply one cycle of inputs, check in_ready before the edge, advance the
  // model by the handshake rules at the edge, then check outputs.
  task automatic applyStimulus(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic ordy, input logic rstn, input logic clr);
    bit acc;
    in_valid    = v;
    a           = av;
    b           = bv;
    out_ready   = ordy;
    rst_n       = rstn;
    stats_clear = clr;
    #1;
    if (m_init) begin
      checkEq("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || ordy)});
    end
    @(posedge clk);
    if (!rstn) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_known = 1'b1;
      m_sum   = '0;
      m_carry = '0;
      m_any   = 1'b0;
      m_txn   = 0;
      m_cc    = 0;
    end else begin
      acc = v && (!m_valid || ordy);
      if (clr) begin
        m_txn = 0;
        m_cc  = 0;
      end else if (acc) begin
        if (m_txn < CNTMAX) m_txn++;
        if (((av & bv) != 0) && (m_cc < CNTMAX)) m_cc++;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_known = 1'b1;
        m_sum   = av ^ bv;
        m_carry = av & bv;
        m_any   = (av & bv) != 0;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
        m_known = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] held_sum;
    int           stream_results;

    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;
    stats_clear = 1'b0;
    stream_results = 0;

    $display("[TB] reset");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    // Idle cycle: in_valid low must not touch the empty slot.
    applyStimulus(1'b0, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);

    $display("[TB] truth table on lane 0");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, {7'b0, i[1]}, {7'b0, i[0]}, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] vector lanes");
    applyStimulus(1'b1, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
    checkEq("vec1_sum_const", {24'b0, sum}, 32'hCC);
    checkEq("vec1_carry_const", {24'b0, carry}, 32'h30);
    applyStimulus(1'b1, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
    checkEq("vec2_sum_const", {24'b0, sum}, 32'hFF);
    checkEq("vec2_any_const", {31'b0, carry_any}, 32'h0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, 1'b0);
      checkEq("bp_held_carry", {24'b0, carry}, 32'h1);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h06, 8'h03, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] streaming");
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      applyStimulus(1'b1, ra, rb, 1'b1, 1'b1, 1'b0);
      if (out_valid === 1'b1) stream_results++;
    end
    checkEq("stream_results", stream_results, 16);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 8'hFF, 8'h0F, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 8'h33, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    $display("[TB] random handshake mix");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
    end
    // A held result must not change while stalled, whatever the inputs do.
    applyStimulus(1'b1, 8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0);
    held_sum = sum;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    checkEq("stall_sum_stable", {24'b0, sum}, {24'b0, held_sum});
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

`ifdef HALF_ADDER_UNIT_STATS_EN
    $display("[TB] statistics");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
    end
    checkEq("txn_saturated", {28'b0, txn_count}, CNTMAX);
    checkEq("carry_saturated", {28'b0, carry_count}, CNTMAX);
    applyStimulus(1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1);
    checkEq("txn_cleared", {28'b0, txn_count}, 0);
    applyStimulus(1'b1, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h0F, 8'h01, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
